// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and decode.
// Holds {inst, pc} pairs in strict FIFO order, presents the oldest entry
// to the decoder and is cleared by a mispredict flush.
// Optional feature: define IBUF_BYPASS_EN to let an instruction arriving
// into an empty buffer appear on out_* in the same cycle.
module inst_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  // Storage is deliberately left unreset; outputs are masked while empty.
  logic [31:0]     inst_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r   [DEPTH];

  logic full_s;
  logic empty_s;
  logic pass_s;
  logic enq_s;
  logic deq_s;

  // Status flags come only from the registered occupancy, so in_ready has
  // no combinational path from out_ready.
  always_comb begin
    full_s  = (count_r == CNT_W'(DEPTH));
    empty_s = (count_r == {CNT_W{1'b0}});
  end

  // Fire conditions; a bypassed instruction is consumed without a write.
  always_comb begin
`ifdef IBUF_BYPASS_EN
    pass_s = empty_s & in_valid & out_ready & ~flush;
`else
    pass_s = 1'b0;
`endif
    enq_s = in_valid & ~full_s & ~pass_s;
    deq_s = out_ready & ~empty_s;
  end

  // Pointer and occupancy update; flush wins over any same-cycle traffic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write the incoming instruction and its PC at the tail slot.
  always_ff @(posedge clock) begin
    if (enq_s && !flush) begin
      inst_mem_r[tail_r] <= in_inst;
      pc_mem_r[tail_r]   <= in_pc;
    end
  end

  // Head presentation: stored entry when occupied, else the bypass path
  // (if built in), else zeros.
  always_comb begin
    in_ready  = ~full_s;
    full      = full_s;
    empty     = empty_s;
    count     = count_r;
    out_valid = 1'b0;
    out_inst  = 32'h0;
    out_pc    = {XLEN{1'b0}};
    if (!empty_s) begin
      out_valid = 1'b1;
      out_inst  = inst_mem_r[head_r];
      out_pc    = pc_mem_r[head_r];
    end else begin
`ifdef IBUF_BYPASS_EN
      if (in_valid && !flush) begin
        out_valid = 1'b1;
        out_inst  = in_inst;
        out_pc    = in_pc;
      end else begin
        out_valid = 1'b0;
      end
`else
      out_valid = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed scoreboard bench for inst_buffer (DEPTH 8, XLEN 32).
module tb_inst_buffer;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  inst_buffer dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .count(count), .full(full), .empty(empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5C3, ~pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after negedge, compare against the model, commit.
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    logic [63:0] e;
    int n;
    bit enq;
    bit deq;
    in_valid = iv; in_pc = pc; in_inst = inst_of(pc); out_ready = ordy; flush = fl;
    #1;
    n = sb.size();
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(n == 8));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("in_ready", 64'(in_ready), 64'(n != 8));
    chk("out_valid", 64'(out_valid), 64'((n > 0) || (BYP && iv && !fl)));
    if (n > 0) e = sb[0];
    else if (BYP && iv && !fl) e = {inst_of(pc), pc};
    else e = 64'h0;
    chk("out_inst", 64'(out_inst), 64'(e[63:32]));
    chk("out_pc", 64'(out_pc), 64'(e[31:0]));
    if (fl) begin
      sb.delete();
    end else if (BYP && n == 0 && iv && ordy) begin
      n = 0;
    end else begin
      enq = iv && (n < 8);
      deq = ordy && (n > 0);
      if (deq) void'(sb.pop_front());
      if (enq) sb.push_back({inst_of(pc), pc});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic enqueue of three, then drain in order.
    cycle(1'b1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill to full, then a held 9th with deq-only then enq-only cycles.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 32'h320, 1'b1, 1'b0);
    cycle(1'b1, 32'h320, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Wrap-around streaming with two preloads.
    cycle(1'b1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h8 + 32'(4 * i), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Flush with five entries and simultaneous enq/deq attempts.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 32'h180, 1'b1, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with four entries.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_empty", 64'(empty), 64'h1);
    chk("arst_full", 64'(full), 64'h0);
    chk("arst_in_ready", 64'(in_ready), 64'h1);
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_out_pc", 64'(out_pc), 64'h0);
    chk("arst_out_inst", 64'(out_inst), 64'h0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    cycle(1'b1, 32'h200, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Empty buffer, instruction arriving with out_ready high.
    cycle(1'b1, 32'h40, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
